// File: rtl/im_loader.sv
// -----------------------------------------------------------------------------
// im_loader
//
// Writer side of the instruction-memory interface. A host streams bytes in:
// a 16-bit word count N (low byte first), then 4*N data bytes (each word
// little-endian), then, when IM_LOADER_CHECKSUM_EN is defined, one checksum
// byte equal to the XOR of every length and data byte. Each completed word is
// written to instruction memory with a one-cycle strobe. The CPU is held in
// reset (cpu_hold = 1) until a complete, valid program has been loaded.
//
// Optional feature macro: IM_LOADER_CHECKSUM_EN (adds the CHECK state and the
// trailing checksum byte). Without it, the last data word (or N == 0) goes
// straight to DONE and LDerror is only raised for N > MAX_WORDS.
//
// Handshake: a byte is taken on a rising clk edge when LDvalid & LDready and
// LDstart is low. LDready is a registered decode of the FSM state; it does not
// depend combinationally on LDvalid, and a byte offered while LDstart is high
// is never taken.
//
// Ports:
//   clk        in   system clock, rising edge
//   reset      in   asynchronous active-low reset
//   LDstart    in   one-cycle pulse that begins (or restarts) a load
//   LDvalid    in   host byte valid
//   LDbyte     in   [7:0] host byte
//   LDready    out  loader can accept a byte this cycle
//   IMwaddr    out  [31:0] instruction-memory write byte address (registered)
//   IMwdata    out  [31:0] assembled instruction word (registered)
//   IMwenable  out  single-cycle write strobe
//   cpu_hold   out  1 = keep the CPU in reset
//   LDdone     out  load completed successfully (level)
//   LDerror    out  load rejected (level)
//   dbg_state  out  [2:0] current FSM state encoding
// -----------------------------------------------------------------------------
module im_loader #(
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
  parameter int          MAX_WORDS = 256,
  parameter logic [31:0] ADDR_STEP = 32'd4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        LDstart,
  input  logic        LDvalid,
  input  logic [7:0]  LDbyte,
  output logic        LDready,
  output logic [31:0] IMwaddr,
  output logic [31:0] IMwdata,
  output logic        IMwenable,
  output logic        cpu_hold,
  output logic        LDdone,
  output logic        LDerror,
  output logic [2:0]  dbg_state
);

  localparam int IW = $clog2(MAX_WORDS + 1);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    LEN0  = 3'd1,
    LEN1  = 3'd2,
    DATA  = 3'd3,
`ifdef IM_LOADER_CHECKSUM_EN
    CHECK = 3'd4,
`endif
    DONE  = 3'd5,
    ERROR = 3'd6
  } state_t;

  // State entered once the payload (possibly empty) has been fully received.
`ifdef IM_LOADER_CHECKSUM_EN
  localparam state_t END_STATE = CHECK;
`else
  localparam state_t END_STATE = DONE;
`endif

  state_t          state, state_next;
  logic [7:0]      len_lo;
  logic [15:0]     n_words;
  logic [IW-1:0]   index;
  logic [1:0]      byte_cnt;
  // Holds the first three bytes of the word in progress; the fourth byte
  // arrives straight from LDbyte when the word is written.
  logic [23:0]     asm_word;
`ifdef IM_LOADER_CHECKSUM_EN
  logic [7:0]      csum;
`endif

  // Control strobes from the next-state logic
  logic        accept;
  logic        restart;
  logic        load_lo;
  logic        load_hi;
  logic        take_data;
  logic        word_wr;
  logic [15:0] n_in;
  logic        last_word;

  assign dbg_state = state;

  function automatic logic ready_of(input state_t s);
    logic r;
    r = 1'b0;
    case (s)
      LEN0, LEN1, DATA: r = 1'b1;
`ifdef IM_LOADER_CHECKSUM_EN
      CHECK:            r = 1'b1;
`endif
      default:          r = 1'b0;
    endcase
    return r;
  endfunction

  // ---------------------------------------------------------------------------
  // FSM state register
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // ---------------------------------------------------------------------------
  // Next-state and control decode
  // ---------------------------------------------------------------------------
  always_comb begin
    state_next = state;
    restart    = 1'b0;
    load_lo    = 1'b0;
    load_hi    = 1'b0;
    take_data  = 1'b0;
    word_wr    = 1'b0;
    accept     = LDvalid & LDready & ~LDstart;
    n_in       = {LDbyte, len_lo};
    // index counts words already written; this word is the last when
    // index + 1 reaches N.
    last_word  = ((32'(index) + 32'd1) == 32'(n_words));

    if (LDstart) begin
      state_next = LEN0;
      restart    = 1'b1;
    end else begin
      case (state)
        LEN0: begin
          if (accept) begin
            load_lo    = 1'b1;
            state_next = LEN1;
          end
        end
        LEN1: begin
          if (accept) begin
            load_hi = 1'b1;
            if (32'(n_in) > 32'(MAX_WORDS)) begin
              state_next = ERROR;
            end else if (n_in == 16'd0) begin
              state_next = END_STATE;
            end else begin
              state_next = DATA;
            end
          end
        end
        DATA: begin
          if (accept) begin
            take_data = 1'b1;
            if (byte_cnt == 2'd3) begin
              word_wr = 1'b1;
              if (last_word) begin
                state_next = END_STATE;
              end
            end
          end
        end
`ifdef IM_LOADER_CHECKSUM_EN
        CHECK: begin
          if (accept) begin
            state_next = (LDbyte == csum) ? DONE : ERROR;
          end
        end
`endif
        default: begin
          // IDLE, DONE and ERROR wait for LDstart
          state_next = state;
        end
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // Datapath and registered outputs. Status outputs are decoded from the next
  // state so they line up with the state register.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      len_lo    <= 8'd0;
      n_words   <= 16'd0;
      index     <= '0;
      byte_cnt  <= 2'd0;
      asm_word  <= 24'd0;
`ifdef IM_LOADER_CHECKSUM_EN
      csum      <= 8'd0;
`endif
      IMwaddr   <= 32'd0;
      IMwdata   <= 32'd0;
      IMwenable <= 1'b0;
      LDready   <= 1'b0;
      cpu_hold  <= 1'b1;
      LDdone    <= 1'b0;
      LDerror   <= 1'b0;
    end else begin
      IMwenable <= word_wr;

      if (restart) begin
        // A partial word is dropped simply by rewinding the byte counter.
        index    <= '0;
        byte_cnt <= 2'd0;
`ifdef IM_LOADER_CHECKSUM_EN
        csum     <= 8'd0;
`endif
      end else begin
        if (load_lo) begin
          len_lo <= LDbyte;
        end
        if (load_hi) begin
          n_words <= n_in;
        end
`ifdef IM_LOADER_CHECKSUM_EN
        if (load_lo || load_hi || take_data) begin
          csum <= csum ^ LDbyte;
        end
`endif
        if (take_data) begin
          asm_word <= {LDbyte, asm_word[23:8]};
          byte_cnt <= byte_cnt + 2'd1;
        end
        if (word_wr) begin
          IMwaddr <= BASE_ADDR + ADDR_STEP * 32'(index);
          IMwdata <= {LDbyte, asm_word};
          index   <= index + IW'(1);
        end
      end

      LDready  <= ready_of(state_next);
      LDdone   <= (state_next == DONE);
      LDerror  <= (state_next == ERROR);
      cpu_hold <= (state_next != DONE);
    end
  end

endmodule

// File: doc/im_loader.md
Name: im_loader

Overview:
- Writer side of the instruction-memory interface: receives a byte stream from a host and assembles 32-bit instruction words, then writes them into instruction memory over the write port.
- Holds the single-cycle CPU in reset until a complete, valid program has been loaded.
- Sits between the external load channel and instructionmemory. Its cpu_hold output gates the core's reset.

Parameters:
BASE_ADDR, 32'h0000_0000, byte address of the first instruction written
MAX_WORDS, 256, maximum accepted word count; larger headers are rejected
ADDR_STEP, 4, byte-address increment per written word (matches PC+4)

Ports:
clk  input  1  system clock, rising edge
reset  input  1  asynchronous, active-low reset
LDstart  input  1  one-cycle pulse that begins (or restarts) a load
LDvalid  input  1  host byte valid
LDbyte  input  8  host byte
LDready  output  1  loader can accept a byte this cycle
IMwaddr  output  32  instruction-memory write byte address
IMwdata  output  32  instruction word, little-endian assembled
IMwenable  output  1  single-cycle write strobe
cpu_hold  output  1  1 = keep the CPU in reset
LDdone  output  1  load completed successfully (level)
LDerror  output  1  load rejected (level)

Behaviour:
- Reset (asynchronous, active-low): state goes to IDLE. All outputs are 0 except cpu_hold = 1. Word index, byte counter and checksum are cleared.
- Acceptance: accept = LDvalid & LDready & ~LDstart. LDready is a registered decode of state: it is 1 in LEN0, LEN1, DATA and CHECK, and 0 in IDLE, DONE and ERROR.
- Stream format:
  - 16-bit word count N, low byte first.
  - Then 4*N data bytes, each word little-endian (first byte goes to bits [7:0]).
  - Then one checksum byte, only when the optional feature is compiled in.
- State transitions:
  - IDLE: LDstart -> LEN0.
  - LEN0: accept -> LEN1, capturing the low byte.
  - LEN1: accept, capturing the high byte, then:
    - N > MAX_WORDS -> ERROR;
    - N == 0 -> CHECK (or DONE when the checksum feature is compiled out);
    - otherwise -> DATA.
  - DATA:
    - Each accept shifts the byte into the assembly register and increments the 2-bit byte counter.
    - On the 4th byte, the next cycle drives IMwenable = 1 for exactly one cycle, with IMwaddr = BASE_ADDR + ADDR_STEP*index and IMwdata = the assembled word. index then increments.
    - After word N-1 is accepted -> CHECK (or DONE when the checksum feature is compiled out).
    - The write pulse may overlap acceptance of the next word's first byte, so LDready stays 1 during the write.
  - CHECK: accept compares the received byte with the running XOR of all length and data bytes. Match -> DONE; mismatch -> ERROR.
  - DONE: cpu_hold = 0, LDdone = 1.
  - ERROR: cpu_hold = 1, LDerror = 1.
  - DONE and ERROR are left only via LDstart (-> LEN0) or reset.
- LDstart in any state:
  - Goes to LEN0 and clears index, byte counter, checksum, LDdone and LDerror.
  - Sets cpu_hold = 1.
  - A partially assembled word is discarded and no write is issued for it.
  - A byte presented in the same cycle as LDstart is not accepted.
- Reset mid-load: the same clear as above, returning to IDLE. Words already written remain in memory, and cpu_hold = 1.
- Outputs IMwaddr and IMwdata are registered and hold their last value when IMwenable = 0.
- Widths: index is clog2(MAX_WORDS+1) bits; the address arithmetic is done in 32 bits and wraps modulo 2^32.

Optional Feature:
- Macro: IM_LOADER_CHECKSUM_EN.
- When defined:
  - The CHECK state and its trailing checksum byte are present.
  - The checksum is the XOR of all bytes from the first length byte through the last data byte.
  - A mismatch goes to ERROR.
- When undefined:
  - No checksum byte is expected and the CHECK state does not exist.
  - The last data word (or N == 0 in LEN1) goes directly to DONE.
  - LDerror is asserted only for N > MAX_WORDS.

Test Plan:
- Stream 02,00,13,05,50,00,93,05,A0,00 with a correct checksum -> two IMwenable pulses:
  - IMwaddr 0x0, IMwdata 0x00500513;
  - IMwaddr 0x4, IMwdata 0x00A00593;
  - then LDdone = 1 and cpu_hold = 0.
- Header 00,00 (+ checksum 00) -> no writes, LDdone = 1, cpu_hold = 0.
- Header 01,01 (N = 257 > 256) -> LDerror = 1, LDready = 0, no writes, cpu_hold = 1.
- Valid 1-word stream with the checksum byte flipped (CHECKSUM_EN) -> the word is written, then LDerror = 1 and cpu_hold stays 1.
- LDstart after 2 data bytes of the second word, then a full 1-word load of 0xDEADBEEF -> the write goes to address 0x0, and the discarded partial word is never written.
- reset asserted low during DATA, then released -> all outputs 0 except cpu_hold = 1, state IDLE, and LDready = 0 until LDstart.
